// File: rtl/avmm_arbiter_2m.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin grant.
// One transaction in flight at a time; reads hold the grant until data returns or time out.
module avmm_arbiter_2m #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                RD_TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    output logic                  m0_waitrequest,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic                  m1_waitrequest,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic [DATA_W-1:0]     s_writedata,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid,
    input  logic                  s_waitrequest,
    output logic                  timeout_err,
    input  logic                  err_clr
);
    localparam int CNT_W = $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             gnt, gnt_next;     // 0 = m0, 1 = m1
    logic             prio, prio_next;   // master favoured when both request
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             timeout_hit;

    logic              req0, req1;
    logic [ADDR_W-1:0] g_address;
    logic              g_read, g_write, g_req, g_wait;
    logic [DATA_W/8-1:0] g_byteenable;
    logic [DATA_W-1:0] g_writedata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign g_address    = gnt ? m1_address    : m0_address;
    assign g_read       = gnt ? m1_read       : m0_read;
    assign g_write      = gnt ? m1_write      : m0_write;
    assign g_byteenable = gnt ? m1_byteenable : m0_byteenable;
    assign g_writedata  = gnt ? m1_writedata  : m0_writedata;
    assign g_req        = g_read | g_write;

    always_comb begin
        state_next   = state;
        gnt_next     = gnt;
        prio_next    = prio;
        cnt_next     = cnt;
        timeout_hit  = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = '0;
        g_wait       = 1'b1;
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_byteenable = '0;
        s_writedata  = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = CMD;
                    gnt_next   = (req0 && req1) ? prio : req1;
                end
            end
            CMD: begin
                // A master that drops its request here gets no slave strobe.
                s_address    = g_address;
                s_read       = g_read;
                s_write      = g_write & ~g_read;
                s_byteenable = g_byteenable;
                s_writedata  = g_writedata;
                g_wait       = s_waitrequest;
                if (!g_req) begin
                    state_next = IDLE;
                end else if (!s_waitrequest) begin
                    if (g_read) begin
                        state_next = WAIT_RD;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                        prio_next  = !gnt;
                    end
                end
            end
            WAIT_RD: begin
                cnt_next = cnt + 1'b1;
                // Real data wins over a timeout landing in the same cycle.
                if (s_readdatavalid) begin
                    rsp_valid  = 1'b1;
                    rsp_data   = s_readdata;
                    state_next = IDLE;
                    prio_next  = !gnt;
                end else if (cnt == CNT_MAX) begin
                    rsp_valid   = 1'b1;
                    rsp_data    = TIMEOUT_DATA;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                    prio_next   = !gnt;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m0_waitrequest   = gnt ? 1'b1 : g_wait;
    assign m1_waitrequest   = gnt ? g_wait : 1'b1;
    assign m0_readdatavalid = rsp_valid & ~gnt;
    assign m1_readdatavalid = rsp_valid & gnt;
    assign m0_readdata      = (rsp_valid && !gnt) ? rsp_data : '0;
    assign m1_readdata      = (rsp_valid && gnt) ? rsp_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            prio        <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            prio  <= prio_next;
            cnt   <= cnt_next;
            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: doc/avmm_arbiter_2m.md
Name: avmm_arbiter_2m

Overview:
- Two-master, one-slave Avalon-MM arbiter with round-robin grant.
- Shares one downstream Avalon-MM slave between the I2C IP master port and a second master, such as the soft CPU data master.
- Only one transaction is in flight at a time; reads hold the grant until readdatavalid returns.
- A read-response timeout guards against a hung slave.

Parameters:
- ADDR_W, 32, address width for both masters and the slave.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- RD_TIMEOUT, 1024, maximum number of cycles spent in WAIT_RD before the arbiter synthesises a response. Must be ≥2.
- TIMEOUT_DATA, 32'hDEAD_BEEF, readdata returned on timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_address, m1_address  in  ADDR_W  master addresses.
- m0_read, m1_read  in  1  read requests.
- m0_write, m1_write  in  1  write requests.
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte enables.
- m0_writedata, m1_writedata  in  DATA_W  write data.
- m0_readdata, m1_readdata  out  DATA_W  returned read data.
- m0_readdatavalid, m1_readdatavalid  out  1  read response strobes.
- m0_waitrequest, m1_waitrequest  out  1  stall to each master.
- s_address  out  ADDR_W  slave address.
- s_read, s_write  out  1  slave read/write strobes.
- s_byteenable  out  DATA_W/8  slave byte enables.
- s_writedata  out  DATA_W  slave write data.
- s_readdata  in  DATA_W  slave read data.
- s_readdatavalid  in  1  slave read response strobe.
- s_waitrequest  in  1  slave stall.
- timeout_err  out  1  sticky flag: a read timed out.
- err_clr  in  1  synchronous clear for timeout_err.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - s_read=0, s_write=0, s_address=0, s_byteenable=0, s_writedata=0.
  - m*_waitrequest=1, m*_readdatavalid=0, m*_readdata=0.
  - timeout_err=0; state=IDLE; round-robin pointer favours m0; timeout counter=0.
- Reset asserted mid-transaction aborts immediately with no response to the master. The slave must itself be reset by the same rst_n.
- Request definition: reqN = mN_read | mN_write. A master asserting both read and write is illegal; read takes precedence.
- States:
  - IDLE: no grant. Both m*_waitrequest=1, s_read=s_write=0.
    - No request: stay in IDLE.
    - One requester: grant it.
    - Both requesting: grant the master not granted last (pointer); pointer starts at m0 after reset.
    - Grant is registered, so arbitration costs exactly 1 cycle. Next state is CMD.
  - CMD: slave command outputs combinationally mirror the granted master's address/read/write/byteenable/writedata.
    - Granted mN_waitrequest = s_waitrequest; the other master's waitrequest stays 1.
    - When s_waitrequest=0:
      - write: accepted this cycle → IDLE; pointer ← granted master.
      - read: accepted → WAIT_RD; timeout counter cleared.
    - If the granted master drops its request while in CMD (protocol violation): → IDLE, no slave strobe that cycle.
  - WAIT_RD: s_read=s_write=0; both m*_waitrequest=1.
    - s_readdatavalid=1: that same cycle, mN_readdatavalid=1 and mN_readdata=s_readdata for the granted master only (combinational route). → IDLE; pointer ← granted master.
    - Counter reaches RD_TIMEOUT-1 without valid: mN_readdatavalid=1 with mN_readdata=TIMEOUT_DATA for one cycle; timeout_err←1; → IDLE; pointer updated.
- Non-granted master: readdatavalid=0 and readdata=0 at all times.
- s_readdatavalid outside WAIT_RD (stray or late) is ignored and not forwarded.
- A valid response and a timeout in the same cycle: real data wins and timeout_err is not set.
- timeout_err: set as above. err_clr=1 clears it; a set in the same cycle as err_clr wins.
- Back-to-back throughput: minimum write period is 2 cycles per transaction (IDLE+CMD); minimum read period is 3 cycles plus slave latency.

Test Plan:
- Single write: m0 writes addr 0x10, data 0xA5A5_0001, be 0xF, slave waitrequest=0 → s_write high exactly 1 cycle, 1 cycle after request; m0_waitrequest low that cycle; m1 untouched.
- Contention: m0 and m1 both request continuous writes from reset → grants alternate m0, m1, m0, m1. Each master sees waitrequest=1 while the other is served.
- Read with latency: m1 reads 0x20; slave holds waitrequest 3 cycles, then returns 0x1234_5678 after 5 cycles → m1_readdatavalid pulses once with 0x1234_5678; m0_readdatavalid stays 0; m0 request is held off until then.
- Timeout: RD_TIMEOUT=8, m0 reads, slave never asserts readdatavalid → m0_readdatavalid with 0xDEAD_BEEF, 8 cycles after acceptance; timeout_err=1. A later stray s_readdatavalid is ignored. err_clr pulse → timeout_err=0.
- Boundary: s_readdatavalid on the final timeout cycle → real data returned, timeout_err stays 0.
- Reset mid-read: rst_n low during WAIT_RD → all outputs at reset values asynchronously. After release, m0 wins the first simultaneous request.
